// File: rtl/mips32_pkg.sv
// Shared MIPS32 pipeline definitions: opcodes, opcode field, MEM-stage FSM states.
package mips32_pkg;

    localparam int DATA_W_DEF = 32;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;

    localparam logic [5:0] OP_ALU   = 6'h00;
    localparam logic [5:0] OP_RI    = 6'h01;
    localparam logic [5:0] OP_LW    = 6'h30;
    localparam logic [5:0] OP_SW    = 6'h31;
    localparam logic [5:0] OP_BNEQZ = 6'h34;
    localparam logic [5:0] OP_BEQZ  = 6'h35;
    localparam logic [5:0] OP_HLT   = 6'h3F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_HALT
    } mem_state_e;

    function automatic logic [5:0] op_of(input logic [31:0] ir);
        return ir[OP_HI:OP_LO];
    endfunction

endpackage

// File: rtl/dmem_if_fsm.sv
// Data-memory req/ack FSM; holds address, write-enable and store data until ack.
module dmem_if_fsm
    import mips32_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt,
    input  logic              we_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              dmem_ack,
    output mem_state_e        state,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              done
);

    // Ack only counts while a request is actually outstanding.
    assign done = (state == ST_ACCESS) && dmem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (halt) begin
                        state <= ST_HALT;
                    end else if (start) begin
                        state      <= ST_ACCESS;
                        dmem_req   <= 1'b1;
                        dmem_we    <= we_in;
                        dmem_addr  <= addr_in;
                        dmem_wdata <= wdata_in;
                    end
                end
                ST_ACCESS: begin
                    if (dmem_ack) begin
                        state    <= ST_IDLE;
                        dmem_req <= 1'b0;
                    end
                end
                default: state <= ST_HALT;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS32 MEM stage: decode, branch resolution, data-memory access and MEM/WB latch.
// Optional build macro MEM_MISALIGN_CHK_EN retires misaligned LW/SW without access and flags misalign_err.
module mem_stage
    import mips32_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [31:0]       NPC_ex,
    input  logic [31:0]       IR_ex,
    input  logic [31:0]       ALU_res,
    input  logic [DATA_W-1:0] B_ex,
    input  logic              sel,
    output logic              stall_o,
    output logic              br_taken,
    output logic [31:0]       br_target,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              wb_valid,
    output logic [31:0]       wb_ir,
    output logic [31:0]       wb_alu,
    output logic [DATA_W-1:0] wb_lmd,
`ifdef MEM_MISALIGN_CHK_EN
    output logic              misalign_err,
`endif
    output logic              halted
);

    mem_state_e  state;
    logic        done;
    logic [5:0]  op;
    logic        is_ld, is_st, is_hlt, taken, misal;
    logic        accept, mem_go, pass;
    logic [31:0] ir_q, alu_q;
    logic        unused_npc;

    assign unused_npc = ^NPC_ex;

    assign op     = op_of(IR_ex);
    assign is_ld  = (op == OP_LW);
    assign is_st  = (op == OP_SW);
    assign is_hlt = (op == OP_HLT);
    assign taken  = ((op == OP_BEQZ) && sel) || ((op == OP_BNEQZ) && !sel);

`ifdef MEM_MISALIGN_CHK_EN
    assign misal = (is_ld || is_st) && (ALU_res[1:0] != 2'b00);
`else
    assign misal = 1'b0;
`endif

    assign accept = in_valid && (state == ST_IDLE);
    assign mem_go = accept && (is_ld || is_st) && !misal;
    assign pass   = accept && !mem_go;
    assign stall_o = (state == ST_ACCESS);

    dmem_if_fsm #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (mem_go),
        .halt       (accept && is_hlt),
        .we_in      (is_st),
        .addr_in    (ALU_res[ADDR_W-1:0]),
        .wdata_in   (B_ex),
        .dmem_ack   (dmem_ack),
        .state      (state),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .done       (done)
    );

    // EX may advance on the issue edge, so the memory op's IR/ALU are kept here for WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q      <= '0;
            alu_q     <= '0;
            wb_valid  <= 1'b0;
            wb_ir     <= '0;
            wb_alu    <= '0;
            wb_lmd    <= '0;
            br_taken  <= 1'b0;
            br_target <= '0;
            halted    <= 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
            misalign_err <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;
            br_taken <= 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
            misalign_err <= 1'b0;
`endif
            if (mem_go) begin
                ir_q  <= IR_ex;
                alu_q <= ALU_res;
            end
            if (pass) begin
                wb_valid <= 1'b1;
                wb_ir    <= IR_ex;
                wb_alu   <= ALU_res;
                if (taken) begin
                    br_taken  <= 1'b1;
                    br_target <= ALU_res;
                end
                if (is_hlt) halted <= 1'b1;
`ifdef MEM_MISALIGN_CHK_EN
                misalign_err <= misal;
`endif
            end else if (done) begin
                wb_valid <= 1'b1;
                wb_ir    <= ir_q;
                wb_alu   <= alu_q;
                if (!dmem_we) wb_lmd <= dmem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for single-cycle ops plus memory/reset/halt sequences.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] NPC_ex, IR_ex, ALU_res, B_ex;
    logic        sel;
    logic        stall_o, br_taken, dmem_req, dmem_we, dmem_ack, wb_valid, halted;
    logic [31:0] br_target, dmem_addr, dmem_wdata, dmem_rdata, wb_ir, wb_alu, wb_lmd;
`ifdef MEM_MISALIGN_CHK_EN
    logic        misalign_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .NPC_ex(NPC_ex), .IR_ex(IR_ex),
        .ALU_res(ALU_res), .B_ex(B_ex), .sel(sel), .stall_o(stall_o), .br_taken(br_taken),
        .br_target(br_target), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_valid(wb_valid), .wb_ir(wb_ir), .wb_alu(wb_alu), .wb_lmd(wb_lmd),
`ifdef MEM_MISALIGN_CHK_EN
        .misalign_err(misalign_err),
`endif
        .halted(halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] alu,
                         input logic [31:0] b, input logic s);
        in_valid = v; IR_ex = ir; ALU_res = alu; B_ex = b; sel = s;
    endtask

    typedef struct {
        logic        v;
        logic [31:0] ir;
        logic [31:0] alu;
        logic        s;
        logic        e_valid;
        logic        e_taken;
        logic [31:0] e_target;
    } vec_t;

    vec_t vecs[7];
    int   stall_cnt;

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0000, 32'h0000_0008, 1'b0, 1'b1, 1'b0, 32'h0000_0000};
        vecs[1] = '{1'b1, 32'hd400_0000, 32'h0000_0104, 1'b1, 1'b1, 1'b1, 32'h0000_0104};
        vecs[2] = '{1'b1, 32'hd400_0000, 32'h0000_0200, 1'b0, 1'b1, 1'b0, 32'h0000_0104};
        vecs[3] = '{1'b1, 32'hd000_0000, 32'h0000_0300, 1'b0, 1'b1, 1'b1, 32'h0000_0300};
        vecs[4] = '{1'b1, 32'hd000_0000, 32'h0000_0400, 1'b1, 1'b1, 1'b0, 32'h0000_0300};
        vecs[5] = '{1'b1, 32'h0c00_0123, 32'h0000_0055, 1'b1, 1'b1, 1'b0, 32'h0000_0300};
        vecs[6] = '{1'b0, 32'hd400_0000, 32'h0000_0777, 1'b1, 1'b0, 1'b0, 32'h0000_0300};

        rst_n = 1'b0; NPC_ex = 32'h4; dmem_ack = 1'b0; dmem_rdata = '0;
        drive(1'b0, '0, '0, '0, 1'b0);
        #12;
        chk("rst_wb_valid", {31'b0, wb_valid}, 0);
        chk("rst_stall", {31'b0, stall_o}, 0);
        chk("rst_req", {31'b0, dmem_req}, 0);
        chk("rst_halted", {31'b0, halted}, 0);
        chk("rst_wb_lmd", wb_lmd, 0);
        rst_n = 1'b1;
        step();

        // single-cycle ops: result on the next edge, then idle cycle
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].v, vecs[i].ir, vecs[i].alu, 32'h0, vecs[i].s);
            step();
            chk($sformatf("v%0d_wb_valid", i), {31'b0, wb_valid}, {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d_br_taken", i), {31'b0, br_taken}, {31'b0, vecs[i].e_taken});
            chk($sformatf("v%0d_br_target", i), br_target, vecs[i].e_target);
            chk($sformatf("v%0d_stall", i), {31'b0, stall_o}, 0);
            chk($sformatf("v%0d_req", i), {31'b0, dmem_req}, 0);
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_wb_alu", i), wb_alu, vecs[i].alu);
                chk($sformatf("v%0d_wb_ir", i), wb_ir, vecs[i].ir);
            end
            drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
            step();
            chk($sformatf("v%0d_pulse_end", i), {30'b0, wb_valid, br_taken}, 0);
        end

        // ack outside ACCESS is ignored
        dmem_ack = 1'b1;
        step();
        chk("idle_ack_wb_valid", {31'b0, wb_valid}, 0);
        chk("idle_ack_req", {31'b0, dmem_req}, 0);
        dmem_ack = 1'b0;

        // store, ack on the 4th request cycle; EX inputs change underneath
        drive(1'b1, 32'hc400_0000, 32'h0000_0010, 32'h0000_0005, 1'b0);
        step();
        drive(1'b0, 32'h0000_0000, 32'h0000_0999, 32'h0000_0abc, 1'b0);
        stall_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) dmem_ack = 1'b1;
            chk($sformatf("st_c%0d_req", c), {31'b0, dmem_req}, 1);
            chk($sformatf("st_c%0d_we", c), {31'b0, dmem_we}, 1);
            chk($sformatf("st_c%0d_addr", c), dmem_addr, 32'h10);
            chk($sformatf("st_c%0d_wdata", c), dmem_wdata, 32'h5);
            chk($sformatf("st_c%0d_wb_valid", c), {31'b0, wb_valid}, 0);
            if (stall_o) stall_cnt++;
            step();
        end
        dmem_ack = 1'b0;
        chk("st_stall_cycles", stall_cnt, 4);
        chk("st_wb_valid", {31'b0, wb_valid}, 1);
        chk("st_wb_ir", wb_ir, 32'hc400_0000);
        chk("st_wb_alu", wb_alu, 32'h10);
        chk("st_wb_lmd_hold", wb_lmd, 0);
        chk("st_req_drop", {31'b0, dmem_req}, 0);
        chk("st_stall_drop", {31'b0, stall_o}, 0);
        step();
        chk("st_pulse_end", {31'b0, wb_valid}, 0);

        // load with immediate ack
        drive(1'b1, 32'hc000_0000, 32'h0000_0020, 32'h0, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        chk("ld_req", {31'b0, dmem_req}, 1);
        chk("ld_we", {31'b0, dmem_we}, 0);
        chk("ld_addr", dmem_addr, 32'h20);
        chk("ld_stall", {31'b0, stall_o}, 1);
        step();
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        chk("ld_wb_valid", {31'b0, wb_valid}, 1);
        chk("ld_wb_lmd", wb_lmd, 32'hDEAD_BEEF);
        chk("ld_wb_alu", wb_alu, 32'h20);
        chk("ld_req_drop", {31'b0, dmem_req}, 0);
        // following ALU op leaves wb_lmd alone
        drive(1'b1, 32'h0000_0000, 32'h0000_0033, 32'h0, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("alu_after_ld_lmd", wb_lmd, 32'hDEAD_BEEF);
        chk("alu_after_ld_alu", wb_alu, 32'h33);

        // reset mid-access
        drive(1'b1, 32'hc400_0000, 32'h0000_0040, 32'h0000_0077, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("rma_req_before", {31'b0, dmem_req}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rma_req", {31'b0, dmem_req}, 0);
        chk("rma_stall", {31'b0, stall_o}, 0);
        chk("rma_addr", dmem_addr, 0);
        chk("rma_wb_lmd", wb_lmd, 0);
        chk("rma_br_target", br_target, 0);
        chk("rma_wb_alu", wb_alu, 0);
        #3 rst_n = 1'b1;
        drive(1'b1, 32'h0000_0000, 32'h0000_0011, 32'h0, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("rma_alu_valid", {31'b0, wb_valid}, 1);
        chk("rma_alu_res", wb_alu, 32'h11);

        // HLT then an ignored load
        drive(1'b1, 32'hfc00_0000, 32'h0, 32'h0, 1'b0);
        step();
        chk("hlt_wb_valid", {31'b0, wb_valid}, 1);
        chk("hlt_wb_ir", wb_ir, 32'hfc00_0000);
        chk("hlt_halted", {31'b0, halted}, 1);
        drive(1'b1, 32'hc000_0000, 32'h0000_0020, 32'h0, 1'b0);
        dmem_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("hlt_c%0d_req", c), {31'b0, dmem_req}, 0);
            chk($sformatf("hlt_c%0d_wb_valid", c), {31'b0, wb_valid}, 0);
            chk($sformatf("hlt_c%0d_stall", c), {31'b0, stall_o}, 0);
            chk($sformatf("hlt_c%0d_halted", c), {31'b0, halted}, 1);
        end
        dmem_ack = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
